// File: rtl/alu_flag_stage.sv
// alu_flag_stage: result/flag stage behind the ALU adder/subtractor.
// Derives N/Z/C/V at push time, holds up to two results in a registered
// skid buffer, and keeps a sticky status register updated on delivery.
module alu_flag_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_cout,
    input  logic             in_op,
    input  logic             in_flags_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags,
    output logic [3:0]       status
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] res_q   [2];
    logic [WIDTH-1:0] res_d   [2];
    logic [3:0]       flags_q [2];
    logic [3:0]       flags_d [2];
    logic [1:0]       fen_q;
    logic [1:0]       fen_d;
    logic             head_q;
    logic             head_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [3:0]       status_q;
    logic [3:0]       status_d;

    logic             push;
    logic             pop;
    logic             tail;
    logic [3:0]       new_flags;
    logic             flag_v;

    // Flag derivation from the incoming operands and result.
    always_comb begin
        flag_v = 1'b0;
        if (in_op) begin
            flag_v = (in_a[MSB] != in_b[MSB]) && (in_res[MSB] != in_a[MSB]);
        end else begin
            flag_v = (in_a[MSB] == in_b[MSB]) && (in_res[MSB] != in_a[MSB]);
        end
        new_flags = {in_res[MSB], (in_res == '0), in_cout, flag_v};
    end

    // Handshake: ready depends only on registered occupancy, never on out_ready.
    always_comb begin
        in_ready  = (count_q < 2'd2) && !rst;
        out_valid = (count_q != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        tail      = head_q ^ count_q[0];
        out_res   = out_valid ? res_q[head_q]   : '0;
        out_flags = out_valid ? flags_q[head_q] : 4'd0;
        status    = status_q;
    end

    // Next-state for storage, pointers, occupancy and sticky status.
    always_comb begin
        res_d    = res_q;
        flags_d  = flags_q;
        fen_d    = fen_q;
        head_d   = head_q;
        count_d  = count_q;
        status_d = status_q;

        if (push) begin
            res_d[tail]   = in_res;
            flags_d[tail] = new_flags;
            fen_d[tail]   = in_flags_en;
        end

        if (pop) begin
            head_d = ~head_q;
            if (fen_q[head_q]) begin
                status_d = flags_q[head_q];
            end
        end

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // State registers; reset discards buffered entries and clears status at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i]   <= '0;
                flags_q[i] <= 4'd0;
            end
            fen_q    <= 2'd0;
            head_q   <= 1'b0;
            count_q  <= 2'd0;
            status_q <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                res_q[i]   <= res_d[i];
                flags_q[i] <= flags_d[i];
            end
            fen_q    <= fen_d;
            head_q   <= head_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage at WIDTH=3.
module tb_alu_flag_stage;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_res;
    logic             in_cout;
    logic             in_op;
    logic             in_flags_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [3:0]       out_flags;
    logic [3:0]       status;

    int n_cmp = 0;
    int n_err = 0;

    alu_flag_stage #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_res      (in_res),
        .in_cout     (in_cout),
        .in_op       (in_op),
        .in_flags_en (in_flags_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_flags   (out_flags),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] res,
                         input logic cout, input logic op, input logic fen);
        in_valid    = 1'b1;
        in_a        = a;
        in_b        = b;
        in_res      = res;
        in_cout     = cout;
        in_op       = op;
        in_flags_en = fen;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_res = '0;
        in_cout = 1'b0; in_op = 1'b0; in_flags_en = 1'b0; out_ready = 1'b0;

        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Sub 5-4=1, no borrow, status updated on delivery.
        out_ready = 1'b1;
        drive(3'b101, 3'b100, 3'b001, 1'b1, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_res", 32'(out_res), 32'd1);
        chk("t1_flags", 32'(out_flags), 32'b0010);
        chk("t1_status_before", 32'(status), 32'd0);
        step();
        chk("t1_status_after", 32'(status), 32'b0010);
        chk("t1_drained", 32'(out_valid), 32'd0);

        // Sub with borrow, then signed overflow.
        drive(3'b100, 3'b101, 3'b111, 1'b0, 1'b1, 1'b1);
        step();
        chk("t2_flags", 32'(out_flags), 32'b1000);
        drive(3'b011, 3'b100, 3'b111, 1'b0, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t2v_flags", 32'(out_flags), 32'b1001);
        chk("t2_status", 32'(status), 32'b1000);
        step();
        chk("t2v_status", 32'(status), 32'b1001);

        // Zero result with flags_en=0 leaves status alone.
        drive(3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        chk("t3_flags", 32'(out_flags), 32'b0110);
        step();
        chk("t3_status_hold", 32'(status), 32'b1001);

        // Add overflow 3+1 and add carry 7+1.
        drive(3'b011, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_v_flags", 32'(out_flags), 32'b1001);
        drive(3'b111, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("add_c_flags", 32'(out_flags), 32'b0110);
        step();

        // Streaming: one result per cycle, occupancy never reaches 2.
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 3'b000, 3'(i), 1'b0, 1'b0, 1'b1);
            step();
            chk("str_valid", 32'(out_valid), 32'd1);
            chk("str_res", 32'(out_res), 32'(i));
            chk("str_flags", 32'(out_flags), {28'd0, (i >= 4), (i == 0), 2'b00});
            chk("str_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("str_drained", 32'(out_valid), 32'd0);
        chk("str_status", 32'(status), 32'b1000);

        // Backpressure: third push waits until a slot frees.
        out_ready = 1'b0;
        drive(3'b010, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1);
        step();
        drive(3'b011, 3'b000, 3'b011, 1'b0, 1'b0, 1'b1);
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        drive(3'b100, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1);
        step();
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_res", 32'(out_res), 32'd2);
        step();
        chk("bp_hold_res2", 32'(out_res), 32'd2);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_res", 32'(out_res), 32'd3);
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_pop2_res", 32'(out_res), 32'd4);
        chk("bp_pop2_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_status", 32'(status), 32'b1000);

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0;
        drive(3'b001, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1);
        step();
        drive(3'b010, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_status", 32'(status), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ar_no_stale", 32'(out_valid), 32'd0);
        chk("ar_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("ar_no_stale2", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
